// File: rtl/mem_arb_pkg.sv
// Shared encodings for the external memory port arbiter: FSM states, grant
// codes and the last-read-winner flag used by round-robin arbitration.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_DR   = 2'd2,
        GNT_DW   = 2'd3
    } gnt_e;

    // Encoding of the last read winner.
    localparam logic LAST_I = 1'b0;
    localparam logic LAST_D = 1'b1;

    // Watchdog counter width; covers TIMEOUT values up to 255.
    localparam int WDOG_W = 8;

    function automatic logic is_read(input gnt_e g);
        return (g == GNT_I) || (g == GNT_DR);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection. Write-back always wins; reads are fixed
// priority (dcache first) or round-robin when ARB_RR_EN is defined.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_rd_req_i,
    input  logic d_rd_req_i,
    input  logic d_wr_req_i,
    input  logic last_grant_i,
    output gnt_e gnt_o
);

`ifdef ARB_RR_EN
    logic both_rd;
    assign both_rd = d_rd_req_i && i_rd_req_i;
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;
`endif

    always_comb begin
        // NOTE: give every always_comb output a default first so no path leaves it unassigned (latch).
        gnt_o = GNT_NONE;
        if (d_wr_req_i) begin
            gnt_o = GNT_DW;
        end
`ifdef ARB_RR_EN
        else if (both_rd) begin
            gnt_o = (last_grant_i == LAST_D) ? GNT_I : GNT_DR;
        end
`else
`endif
        else if (d_rd_req_i) begin
            gnt_o = GNT_DR;
        end else if (i_rd_req_i) begin
            gnt_o = GNT_I;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between icache fills and dcache fills/write-backs,
// with a watchdog abort. Define ARB_RR_EN for round-robin read arbitration.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              i_rd_valid,
    output logic [DATA_W-1:0] i_rd_data,
    input  logic              d_rd_req,
    input  logic [ADDR_W-1:0] d_rd_addr,
    output logic              d_rd_valid,
    output logic [DATA_W-1:0] d_rd_data,
    input  logic              d_wr_req,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [DATA_W-1:0] d_wr_data,
    output logic              d_wr_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rden,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              err,
    output logic              busy
);

    localparam logic [WDOG_W-1:0] CNT_LAST = WDOG_W'(TIMEOUT - 1);

    state_e              state_q, state_d;
    gnt_e                gnt_q, gnt_d, pick_gnt;
    logic [WDOG_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_rden_q, mem_rden_d;
    logic                mem_wren_q, mem_wren_d;
    logic                i_rd_valid_q, i_rd_valid_d;
    logic [DATA_W-1:0]   i_rd_data_q, i_rd_data_d;
    logic                d_rd_valid_q, d_rd_valid_d;
    logic [DATA_W-1:0]   d_rd_data_q, d_rd_data_d;
    logic                d_wr_done_q, d_wr_done_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic                last_grant;

`ifdef ARB_RR_EN
    logic last_grant_q, last_grant_d;

    // Only read grants move the round-robin pointer.
    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == IDLE) begin
            if (pick_gnt == GNT_DR) begin
                last_grant_d = LAST_D;
            end else if (pick_gnt == GNT_I) begin
                last_grant_d = LAST_I;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= LAST_I;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign last_grant = last_grant_q;
`else
    assign last_grant = LAST_I;
`endif

    mem_arb_pick u_pick (
        .i_rd_req_i   (i_rd_req),
        .d_rd_req_i   (d_rd_req),
        .d_wr_req_i   (d_wr_req),
        .last_grant_i (last_grant),
        .gnt_o        (pick_gnt)
    );

    // Every output register is loaded with its value for the coming cycle.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        cnt_d        = cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_rden_d   = 1'b0;
        mem_wren_d   = 1'b0;
        i_rd_valid_d = 1'b0;
        i_rd_data_d  = '0;
        d_rd_valid_d = 1'b0;
        d_rd_data_d  = '0;
        d_wr_done_d  = 1'b0;
        err_d        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_gnt != GNT_NONE) begin
                    state_d = ISSUE;
                    gnt_d   = pick_gnt;
                    cnt_d   = '0;
                    unique case (pick_gnt)
                        GNT_DW: begin
                            mem_addr_d  = d_wr_addr;
                            mem_wdata_d = d_wr_data;
                        end
                        GNT_DR: begin
                            mem_addr_d  = d_rd_addr;
                            mem_wdata_d = '0;
                        end
                        default: begin
                            mem_addr_d  = i_rd_addr;
                            mem_wdata_d = '0;
                        end
                    endcase
                    mem_rden_d = is_read(pick_gnt);
                    mem_wren_d = (pick_gnt == GNT_DW);
                end
            end

            ISSUE: begin
                // An ack in the timeout cycle still completes the access cleanly.
                if (mem_ack || (cnt_q == CNT_LAST)) begin
                    state_d = RESP;
                    cnt_d   = '0;
                    err_d   = !mem_ack;
                    unique case (gnt_q)
                        GNT_I: begin
                            i_rd_valid_d = 1'b1;
                            i_rd_data_d  = mem_ack ? mem_rdata : '0;
                        end
                        GNT_DR: begin
                            d_rd_valid_d = 1'b1;
                            d_rd_data_d  = mem_ack ? mem_rdata : '0;
                        end
                        GNT_DW: begin
                            d_wr_done_d = 1'b1;
                        end
                        default: begin
                            err_d = 1'b0;
                        end
                    endcase
                end else begin
                    cnt_d      = cnt_q + 1'b1;
                    mem_rden_d = is_read(gnt_q);
                    mem_wren_d = (gnt_q == GNT_DW);
                end
            end

            RESP: begin
                state_d = IDLE;
                gnt_d   = GNT_NONE;
                cnt_d   = '0;
            end

            default: begin
                state_d = IDLE;
                gnt_d   = GNT_NONE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            gnt_q        <= GNT_NONE;
            cnt_q        <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_rden_q   <= 1'b0;
            mem_wren_q   <= 1'b0;
            i_rd_valid_q <= 1'b0;
            i_rd_data_q  <= '0;
            d_rd_valid_q <= 1'b0;
            d_rd_data_q  <= '0;
            d_wr_done_q  <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            cnt_q        <= cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_rden_q   <= mem_rden_d;
            mem_wren_q   <= mem_wren_d;
            i_rd_valid_q <= i_rd_valid_d;
            i_rd_data_q  <= i_rd_data_d;
            d_rd_valid_q <= d_rd_valid_d;
            d_rd_data_q  <= d_rd_data_d;
            d_wr_done_q  <= d_wr_done_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_rden   = mem_rden_q;
    assign mem_wren   = mem_wren_q;
    assign i_rd_valid = i_rd_valid_q;
    assign i_rd_data  = i_rd_data_q;
    assign d_rd_valid = d_rd_valid_q;
    assign d_rd_data  = d_rd_data_q;
    assign d_wr_done  = d_wr_done_q;
    assign err        = err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency, priority, arbitration order,
// watchdog timeout, ack-at-timeout and asynchronous reset mid-transaction.
module tb_mem_port_arbiter;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;

    logic              clk;
    logic              rst_n;
    logic              i_rd_req;
    logic [ADDR_W-1:0] i_rd_addr;
    logic              i_rd_valid;
    logic [DATA_W-1:0] i_rd_data;
    logic              d_rd_req;
    logic [ADDR_W-1:0] d_rd_addr;
    logic              d_rd_valid;
    logic [DATA_W-1:0] d_rd_data;
    logic              d_wr_req;
    logic [ADDR_W-1:0] d_wr_addr;
    logic [DATA_W-1:0] d_wr_data;
    logic              d_wr_done;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rden;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              err;
    logic              busy;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rd_req   (i_rd_req),
        .i_rd_addr  (i_rd_addr),
        .i_rd_valid (i_rd_valid),
        .i_rd_data  (i_rd_data),
        .d_rd_req   (d_rd_req),
        .d_rd_addr  (d_rd_addr),
        .d_rd_valid (d_rd_valid),
        .d_rd_data  (d_rd_data),
        .d_wr_req   (d_wr_req),
        .d_wr_addr  (d_wr_addr),
        .d_wr_data  (d_wr_data),
        .d_wr_done  (d_wr_done),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rden   (mem_rden),
        .mem_wren   (mem_wren),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .err        (err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [3:0] pulses();
        return {i_rd_valid, d_rd_valid, d_wr_done, err};
    endfunction

    initial begin
        int dgrants;
        int exp_dgrants;
        logic exp_d;

        rst_n     = 1'b0;
        i_rd_req  = 1'b0;
        i_rd_addr = '0;
        d_rd_req  = 1'b0;
        d_rd_addr = '0;
        d_wr_req  = 1'b0;
        d_wr_addr = '0;
        d_wr_data = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        tick();
        tick();

        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_strobes", {30'd0, mem_rden, mem_wren}, 32'd0);
        check("rst_pulses", {28'd0, pulses()}, 32'd0);
        check("rst_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_data", i_rd_data | d_rd_data | mem_wdata, 32'd0);
        rst_n = 1'b1;

        // icache fill with one-cycle ack
        i_rd_req  = 1'b1;
        i_rd_addr = 16'h0040;
        tick();
        check("t1_rden", {31'd0, mem_rden}, 32'd1);
        check("t1_wren", {31'd0, mem_wren}, 32'd0);
        check("t1_addr", {16'd0, mem_addr}, 32'h0040);
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_no_pulse_yet", {28'd0, pulses()}, 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        tick();
        check("t1_pulses", {28'd0, pulses()}, 32'b1000);
        check("t1_data", i_rd_data, 32'hDEADBEEF);
        check("t1_rden_off", {31'd0, mem_rden}, 32'd0);
        i_rd_req = 1'b0;
        mem_ack  = 1'b0;
        tick();
        check("t1_idle_pulses", {28'd0, pulses()}, 32'd0);
        check("t1_idle_busy", {31'd0, busy}, 32'd0);

        // write-back beats a simultaneous dcache fill
        d_wr_req  = 1'b1;
        d_wr_addr = 16'h1234;
        d_wr_data = 32'hCAFEF00D;
        d_rd_req  = 1'b1;
        d_rd_addr = 16'h5678;
        tick();
        check("t2_wren", {31'd0, mem_wren}, 32'd1);
        check("t2_rden", {31'd0, mem_rden}, 32'd0);
        check("t2_waddr", {16'd0, mem_addr}, 32'h1234);
        check("t2_wdata", mem_wdata, 32'hCAFEF00D);
        mem_ack = 1'b1;
        tick();
        check("t2_wr_done", {28'd0, pulses()}, 32'b0010);
        check("t2_strobes_off", {30'd0, mem_rden, mem_wren}, 32'd0);
        d_wr_req  = 1'b0;
        d_wr_addr = 16'hFFFF;
        mem_ack   = 1'b0;
        tick();
        check("t2_idle_busy", {31'd0, busy}, 32'd0);
        tick();
        check("t2_rd_rden", {31'd0, mem_rden}, 32'd1);
        check("t2_rd_wren", {31'd0, mem_wren}, 32'd0);
        check("t2_rd_addr", {16'd0, mem_addr}, 32'h5678);
        mem_ack   = 1'b1;
        mem_rdata = 32'h11112222;
        tick();
        check("t2_rd_pulses", {28'd0, pulses()}, 32'b0100);
        check("t2_rd_data", d_rd_data, 32'h11112222);
        d_rd_req = 1'b0;
        mem_ack  = 1'b0;
        tick();

        // both reads held for four transactions
        apply_reset();
        d_rd_req  = 1'b1;
        d_rd_addr = 16'h0200;
        i_rd_req  = 1'b1;
        i_rd_addr = 16'h0100;
        dgrants   = 0;
`ifdef ARB_RR_EN
        exp_dgrants = 2;
`else
        exp_dgrants = 4;
`endif
        for (int t = 0; t < 4; t++) begin
`ifdef ARB_RR_EN
            exp_d = (t % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            tick();
            check($sformatf("t3_addr_%0d", t), {16'd0, mem_addr}, exp_d ? 32'h0200 : 32'h0100);
            mem_ack   = 1'b1;
            mem_rdata = 32'hA0000000 + 32'(t);
            tick();
            check($sformatf("t3_pulses_%0d", t), {28'd0, pulses()}, exp_d ? 32'b0100 : 32'b1000);
            if (d_rd_valid) dgrants++;
            mem_ack = 1'b0;
            tick();
        end
        check("t3_dgrants", 32'(dgrants), 32'(exp_dgrants));
        d_rd_req = 1'b0;
        i_rd_req = 1'b0;
        tick();

        // watchdog abort on a dcache fill
        d_rd_req  = 1'b1;
        d_rd_addr = 16'h0ABC;
        mem_rdata = 32'hFFFFFFFF;
        tick();
        for (int k = 1; k <= TIMEOUT; k++) begin
            check($sformatf("t4_issue_%0d", k), {28'd0, busy, mem_rden, d_rd_valid, err}, 32'b1100);
            tick();
        end
        check("t4_abort_pulses", {28'd0, pulses()}, 32'b0101);
        check("t4_abort_data", d_rd_data, 32'd0);
        check("t4_abort_rden", {31'd0, mem_rden}, 32'd0);
        d_rd_req = 1'b0;
        tick();
        check("t4_idle", {27'd0, busy, pulses()}, 32'd0);

        // ack lands in the same cycle as the timeout
        i_rd_req  = 1'b1;
        i_rd_addr = 16'h0044;
        tick();
        for (int k = 1; k <= TIMEOUT; k++) begin
            check($sformatf("t5_issue_%0d", k), {30'd0, mem_rden, i_rd_valid}, 32'b10);
            if (k == TIMEOUT) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'h0BADF00D;
            end
            tick();
        end
        check("t5_pulses", {28'd0, pulses()}, 32'b1000);
        check("t5_data", i_rd_data, 32'h0BADF00D);
        i_rd_req = 1'b0;
        mem_ack  = 1'b0;
        tick();

        // asynchronous reset while an ack is pending
        d_rd_req  = 1'b1;
        d_rd_addr = 16'h0321;
        tick();
        check("t6_issue_rden", {31'd0, mem_rden}, 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h55AA55AA;
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_ctl", {26'd0, busy, mem_rden, pulses()}, 32'd0);
        check("t6_async_addr", {16'd0, mem_addr}, 32'd0);
        tick();
        d_rd_req = 1'b0;
        mem_ack  = 1'b0;
        rst_n    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("t6_quiet_%0d", k), {27'd0, busy, pulses()}, 32'd0);
        end
        i_rd_req  = 1'b1;
        i_rd_addr = 16'h0040;
        tick();
        check("t6_next_addr", {16'd0, mem_addr}, 32'h0040);
        mem_ack   = 1'b1;
        mem_rdata = 32'h12345678;
        tick();
        check("t6_next_pulses", {28'd0, pulses()}, 32'b1000);
        check("t6_next_data", i_rd_data, 32'h12345678);
        i_rd_req = 1'b0;
        mem_ack  = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory port between the instruction cache (read fills only) and the data cache (read fills plus dirty write-backs).
- Grants one transaction at a time and sequences the memory handshake.
- Returns read data or a write completion to the granted requester.
- Includes a watchdog that aborts memory transactions that are never acknowledged.

Parameters:
- ADDR_W, 16, memory address width (byte address, same as the cache address).
- DATA_W, 32, memory data word width.
- TIMEOUT, 15, maximum cycles in ISSUE without mem_ack before abort (1..255).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_rd_req  in  1  icache read-fill request, level, held until i_rd_valid
i_rd_addr  in  ADDR_W  icache fill address
i_rd_valid  out  1  one-cycle pulse: i_rd_data valid / transaction finished
i_rd_data  out  DATA_W  fill data to icache
d_rd_req  in  1  dcache read-fill request, level, held until d_rd_valid
d_rd_addr  in  ADDR_W  dcache fill address
d_rd_valid  out  1  one-cycle pulse: d_rd_data valid
d_rd_data  out  DATA_W  fill data to dcache
d_wr_req  in  1  dcache write-back request, level, held until d_wr_done
d_wr_addr  in  ADDR_W  write-back address
d_wr_data  in  DATA_W  write-back data
d_wr_done  out  1  one-cycle pulse: write-back accepted by memory
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rden  out  1  memory read enable
mem_wren  out  1  memory write enable
mem_rdata  in  DATA_W  memory read data, valid when mem_ack=1
mem_ack  in  1  memory completes the current access this cycle
err  out  1  one-cycle pulse with the response when the transaction timed out
busy  out  1  state != IDLE

Behaviour:
- Clocking and reset: single clk domain. rst_n is asynchronous and active-low.
  - Reset forces state IDLE and clears every output, the grant register, the watchdog counter and last_grant.
  - Reset mid-transaction drops the transaction silently; no response pulse is generated.
- All outputs are registered.
- FSM states:
  - IDLE: samples requests. If any request is present, latches the grant, address and write data, then goes to ISSUE next cycle. Otherwise stays in IDLE.
  - ISSUE: drives mem_addr and mem_wdata from the latch. Holds mem_rden=1 for a read grant, or mem_wren=1 for a write grant, every cycle until exit. The watchdog counter increments each cycle.
    - mem_ack=1: captures mem_rdata for a read grant, then goes to RESP.
    - Counter reaches TIMEOUT with no ack: goes to RESP with the abort flag set.
    - mem_ack in the same cycle as the timeout: the ack wins and no error is raised.
  - RESP: for exactly one cycle, pulses the granted requester's valid/done. Read data equals the captured word, or 0 if aborted. err=1 if aborted. mem_rden and mem_wren are 0. Next state is IDLE and the counter clears.
- Latency: request seen in IDLE at cycle N, ISSUE at N+1. If mem_ack arrives at N+1, the response pulse is at N+2. Each cycle of ack delay adds one cycle.
- Handshake: a requester drops its req on the edge after it sees its pulse, so IDLE never re-grants a completed request. Address and data are ignored after the IDLE latch.
- Priority:
  - d_wr_req always wins, so an eviction reaches memory before the fill that replaced it.
  - Between reads, d_rd beats i_rd (fixed priority) unless ARB_RR_EN is defined.
- Simultaneous requests: exactly one grant per IDLE visit. Losers stay pending and are re-evaluated in the next IDLE cycle after RESP.
- Minimum back-to-back spacing: 3 cycles per transaction (IDLE, ISSUE, RESP).

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: read arbitration is round-robin between d_rd and i_rd.
  - A 1-bit last_grant register, reset to icache, records the last read winner.
  - When both reads request, the one not granted last wins.
  - Write-back keeps absolute priority and does not update last_grant.
- Undefined: fixed priority d_wr > d_rd > i_rd, and no last_grant register exists.

Decomposition:
- Package mem_arb_pkg holds:
  - FSM state encoding: IDLE=0, ISSUE=1, RESP=2 (2 bits).
  - Grant encoding: GNT_NONE, GNT_I, GNT_DR, GNT_DW (2 bits).
- One combinational sub-module, mem_arb_pick.
  - Inputs: the three requests and last_grant.
  - Output: the grant code.
  - Contains the ARB_RR_EN conditional logic.
- The FSM, latches and watchdog stay in the top module.

Test Plan:
- i_rd_req=1, addr 0x0040; memory acks 1 cycle after issue with 0xDEADBEEF -> mem_rden high 1 cycle at N+1; i_rd_valid pulses at N+2 with i_rd_data=0xDEADBEEF; err=0.
- d_wr_req (addr 0x1234, data 0xCAFEF00D) and d_rd_req (addr 0x5678) raised in the same cycle -> write issued first (mem_wren, mem_addr=0x1234); d_wr_done pulses; then the read is issued with mem_rden and mem_addr=0x5678.
- d_rd_req and i_rd_req held continuously, 4 transactions -> fixed priority: 4 dcache grants and 0 icache; with ARB_RR_EN: alternating D, I, D, I.
- Read issued with mem_ack never asserted, TIMEOUT=15 -> RESP after 15 ISSUE cycles; d_rd_valid=1, err=1, d_rd_data=0; FSM back to IDLE.
- mem_ack on the 15th ISSUE cycle (coincides with timeout) -> err=0 and data captured.
- rst_n driven low during ISSUE with mem_ack pending -> all outputs 0 immediately (asynchronous); no valid/done pulse after release; next request is serviced normally.
